// File: rtl/textlcd_pkg.sv
// Shared types and HD44780 constants for the textlcd bus sequencer.
package textlcd_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_LOAD,
    ST_SETUP,
    ST_E_HIGH,
    ST_HOLD,
    ST_EXEC,
    ST_IDLE
  } state_e;

  localparam int unsigned INIT_LEN = 6;
  localparam int unsigned IDX_W    = 3;

  localparam logic [7:0] CLEAR     = 8'h01;
  localparam logic [7:0] HOME      = 8'h02;
  localparam logic [7:0] HOME_ALT  = 8'h03;
  localparam logic [7:0] FUNC_8B2L = 8'h38;
  localparam logic [7:0] DISP_ON   = 8'h0C;
  localparam logic [7:0] ENTRY_INC = 8'h06;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcd_byte_t;

  // Clear and return-home need the long execution wait
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && ((data == CLEAR) || (data == HOME) || (data == HOME_ALT));
  endfunction

endpackage

// File: rtl/textlcd_init_rom.sv
// Power-on initialisation byte table for an HD44780 in 8-bit, 2-line mode.
module textlcd_init_rom
  import textlcd_pkg::*;
(
  input  logic [IDX_W-1:0] idx_i,
  output logic             rs_o,
  output logic [7:0]       data_o
);

  always_comb begin
    rs_o   = 1'b0;
    data_o = 8'h00;
    case (idx_i)
      3'd0, 3'd1, 3'd2: data_o = FUNC_8B2L;
      3'd3:             data_o = DISP_ON;
      3'd4:             data_o = CLEAR;
      3'd5:             data_o = ENTRY_INC;
      default:          data_o = 8'h00;
    endcase
  end

endmodule

// File: rtl/textlcd_bus_sequencer.sv
// HD44780 8-bit bus sequencer: autonomous power-on init, then one byte per
// accepted request with programmable setup / enable / hold / execution timing.
module textlcd_bus_sequencer
  import textlcd_pkg::*;
#(
  parameter int unsigned T_POWERUP   = 750000,
  parameter int unsigned T_SETUP     = 3,
  parameter int unsigned T_E_HIGH    = 12,
  parameter int unsigned T_HOLD      = 3,
  parameter int unsigned T_EXEC      = 2500,
  parameter int unsigned T_EXEC_LONG = 82000
) (
  input  logic       ACLK,
  input  logic       ARESETN,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       init_done,
  output logic       busy,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_data
);

  localparam int unsigned T_MAX_0 = (T_POWERUP > T_EXEC_LONG) ? T_POWERUP : T_EXEC_LONG;
  localparam int unsigned T_MAX_1 = (T_EXEC > T_E_HIGH) ? T_EXEC : T_E_HIGH;
  localparam int unsigned T_MAX_2 = (T_SETUP > T_HOLD) ? T_SETUP : T_HOLD;
  localparam int unsigned T_MAX_3 = (T_MAX_0 > T_MAX_1) ? T_MAX_0 : T_MAX_1;
  localparam int unsigned T_MAX   = (T_MAX_3 > T_MAX_2) ? T_MAX_3 : T_MAX_2;
  localparam int unsigned CNT_W   = $clog2(T_MAX + 1);

  if ((T_POWERUP == 0) || (T_SETUP == 0) || (T_E_HIGH == 0) ||
      (T_HOLD == 0) || (T_EXEC == 0) || (T_EXEC_LONG == 0)) begin : g_param_check
    $error("textlcd_bus_sequencer: all timing parameters must be at least 1");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  lcd_byte_t        req_q, req_d;
  logic             init_done_q, init_done_d;
  logic             req_ready_q, req_ready_d;
  logic             busy_q;
  logic             lcd_rs_q, lcd_rs_d;
  logic             lcd_e_q, lcd_e_d;
  logic [7:0]       lcd_data_q, lcd_data_d;
  logic             lcd_rw_q;
  logic             rom_rs;
  logic [7:0]       rom_data;
  logic             cnt_zero;

  textlcd_init_rom u_init_rom (
    .idx_i  (idx_q),
    .rs_o   (rom_rs),
    .data_o (rom_data)
  );

  assign cnt_zero = (cnt_q == '0);

  // Timing FSM: each timed state loads T-1 on entry and leaves when the counter hits 0
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    req_d       = req_q;
    init_done_d = init_done_q;
    req_ready_d = 1'b0;
    lcd_rs_d    = lcd_rs_q;
    lcd_e_d     = lcd_e_q;
    lcd_data_d  = lcd_data_q;

    case (state_q)
      ST_PWRUP: begin
        if (cnt_zero) begin
          state_d = ST_LOAD;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_LOAD: begin
        lcd_rs_d   = init_done_q ? req_q.rs : rom_rs;
        lcd_data_d = init_done_q ? req_q.data : rom_data;
        state_d    = ST_SETUP;
        cnt_d      = CNT_W'(T_SETUP - 1);
      end
      ST_SETUP: begin
        if (cnt_zero) begin
          lcd_e_d = 1'b1;
          state_d = ST_E_HIGH;
          cnt_d   = CNT_W'(T_E_HIGH - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_E_HIGH: begin
        if (cnt_zero) begin
          lcd_e_d = 1'b0;
          state_d = ST_HOLD;
          cnt_d   = CNT_W'(T_HOLD - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_zero) begin
          state_d = ST_EXEC;
          cnt_d   = is_long_cmd(lcd_rs_q, lcd_data_q) ? CNT_W'(T_EXEC_LONG - 1)
                                                      : CNT_W'(T_EXEC - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_EXEC: begin
        if (cnt_zero) begin
          if (!init_done_q) begin
            idx_d = idx_q + IDX_W'(1);
            if (idx_q == IDX_W'(INIT_LEN - 1)) begin
              init_done_d = 1'b1;
              state_d     = ST_IDLE;
            end else begin
              state_d = ST_LOAD;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_IDLE: begin
        // ready is registered, so it rises one cycle after IDLE is entered
        if (req_valid && req_ready_q) begin
          req_d   = '{rs: req_rs, data: req_data};
          state_d = ST_LOAD;
        end else begin
          req_ready_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_PWRUP;
        cnt_d   = CNT_W'(T_POWERUP - 1);
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= ST_PWRUP;
      cnt_q       <= CNT_W'(T_POWERUP - 1);
      idx_q       <= '0;
      req_q       <= '0;
      init_done_q <= 1'b0;
      req_ready_q <= 1'b0;
      busy_q      <= 1'b1;
      lcd_rs_q    <= 1'b0;
      lcd_e_q     <= 1'b0;
      lcd_data_q  <= 8'h00;
      lcd_rw_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      req_q       <= req_d;
      init_done_q <= init_done_d;
      req_ready_q <= req_ready_d;
      busy_q      <= ~req_ready_d;
      lcd_rs_q    <= lcd_rs_d;
      lcd_e_q     <= lcd_e_d;
      lcd_data_q  <= lcd_data_d;
      lcd_rw_q    <= 1'b0;
    end
  end

  assign req_ready = req_ready_q;
  assign busy      = busy_q;
  assign init_done = init_done_q;
  assign lcd_rs    = lcd_rs_q;
  assign lcd_rw    = lcd_rw_q;
  assign lcd_e     = lcd_e_q;
  assign lcd_data  = lcd_data_q;

endmodule

// File: tb/tb_textlcd_bus_sequencer.sv
// Scoreboard bench for textlcd_bus_sequencer: expected LCD bytes are queued by
// the stimulus and checked by a monitor on every E pulse.
module tb_textlcd_bus_sequencer;

  localparam int T_PU = 20;
  localparam int T_SU = 2;
  localparam int T_EH = 4;
  localparam int T_HD = 2;
  localparam int T_EX = 10;
  localparam int T_EL = 40;
  localparam int GAP_N = T_HD + T_EX + 1 + T_SU;
  localparam int GAP_L = T_HD + T_EL + 1 + T_SU;

  logic       ACLK;
  logic       ARESETN;
  logic       req_valid;
  logic       req_ready;
  logic       req_rs;
  logic [7:0] req_data;
  logic       init_done;
  logic       busy;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;
  logic [7:0] lcd_data;

  textlcd_bus_sequencer #(
    .T_POWERUP   (T_PU),
    .T_SETUP     (T_SU),
    .T_E_HIGH    (T_EH),
    .T_HOLD      (T_HD),
    .T_EXEC      (T_EX),
    .T_EXEC_LONG (T_EL)
  ) dut (
    .ACLK      (ACLK),
    .ARESETN   (ARESETN),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rs    (req_rs),
    .req_data  (req_data),
    .init_done (init_done),
    .busy      (busy),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_e     (lcd_e),
    .lcd_data  (lcd_data)
  );

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         gap;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   pulses = 0;
  int   rw_bad = 0;
  int   rise_cyc = 0;
  int   fall_cyc = 0;
  int   first_rise = 0;

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;
  always @(posedge ACLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_to(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: got no event, expected one within the cycle budget (t=%0t)", nm, $time);
  endtask

  // Monitor: pops one expected byte per E rising edge, checks width/stability/gap
  initial begin : monitor
    logic       prev_e;
    logic       fresh;
    logic [8:0] hold_bus;
    int         width;
    int         last_fall;
    bit         stable_ok;
    exp_t       x;
    prev_e = 1'b0; fresh = 1'b1; hold_bus = '0; width = 0; last_fall = 0; stable_ok = 1'b1;
    forever begin
      @(negedge ACLK);
      if (!ARESETN) begin
        prev_e = 1'b0;
        fresh  = 1'b1;
      end else begin
        if (lcd_rw !== 1'b0) rw_bad++;
        if (lcd_e && !prev_e) begin
          pulses++;
          width     = 1;
          stable_ok = 1'b1;
          hold_bus  = {lcd_rs, lcd_data};
          rise_cyc  = cyc;
          if (fresh) first_rise = cyc;
          if (sb.size() == 0) begin
            fail_to("unexpected_e_pulse");
          end else begin
            x = sb.pop_front();
            chk("pulse_rs", 32'(lcd_rs), 32'(x.rs));
            chk("pulse_data", 32'(lcd_data), 32'(x.data));
            if (x.gap > 0 && !fresh) chk("pulse_gap", 32'(cyc - last_fall), 32'(x.gap));
          end
          fresh = 1'b0;
        end else if (lcd_e && prev_e) begin
          width++;
          if ({lcd_rs, lcd_data} !== hold_bus) stable_ok = 1'b0;
        end else if (!lcd_e && prev_e) begin
          chk("e_width", 32'(width), 32'(T_EH));
          chk("e_bus_stable", 32'(stable_ok), 32'd1);
          last_fall = cyc;
          fall_cyc  = cyc;
        end
        prev_e = lcd_e;
      end
    end
  end

  task automatic push_init();
    sb.push_back('{1'b0, 8'h38, 0});
    sb.push_back('{1'b0, 8'h38, GAP_N});
    sb.push_back('{1'b0, 8'h38, GAP_N});
    sb.push_back('{1'b0, 8'h0C, GAP_N});
    sb.push_back('{1'b0, 8'h01, GAP_N});
    sb.push_back('{1'b0, 8'h06, GAP_L});
  endtask

  task automatic wait_ready(input string nm, input int budget);
    int n;
    n = 0;
    @(negedge ACLK);
    while (!req_ready && n < budget) begin
      @(negedge ACLK);
      n++;
    end
    if (!req_ready) fail_to(nm);
  endtask

  // Counts negedges with ready low after an accept; returns at a negedge with ready high
  task automatic count_low(output int low);
    int n;
    low = 0;
    n = 0;
    do begin
      @(negedge ACLK);
      n++;
      if (!req_ready) low++;
    end while (!req_ready && n < 200);
    if (!req_ready) fail_to("ready_return");
  endtask

  task automatic send(input logic rs, input logic [7:0] d, input int exp_low, input bit timing);
    int k;
    int n;
    int low;
    wait_ready("send_ready", 500);
    req_valid = 1'b1; req_rs = rs; req_data = d;
    sb.push_back('{rs, d, 0});
    @(posedge ACLK); #1;
    k = cyc;
    req_valid = 1'b0;
    low = 0;
    n = 0;
    do begin
      @(negedge ACLK);
      n++;
      if (timing && cyc == k + 1) begin
        chk("wr_rs_k1", 32'(lcd_rs), 32'(rs));
        chk("wr_data_k1", 32'(lcd_data), 32'(d));
      end
      if (timing && cyc == k + 9) chk("wr_data_held_k9", 32'(lcd_data), 32'(d));
      if (!req_ready) low++;
    end while (!req_ready && n < 200);
    if (!req_ready) fail_to("send_return");
    chk("ready_low_cycles", 32'(low), 32'(exp_low));
    chk("busy_after_xfer", 32'(busy), 32'd0);
    if (timing) begin
      chk("e_rise_offset", 32'(rise_cyc - k), 32'd3);
      chk("e_fall_offset", 32'(fall_cyc - k), 32'd7);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_init_done"}, 32'(init_done), 32'd0);
    chk({tag, "_e"}, 32'(lcd_e), 32'd0);
    chk({tag, "_rs"}, 32'(lcd_rs), 32'd0);
    chk({tag, "_data"}, 32'(lcd_data), 32'd0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int         rel;
    int         p0;
    int         n;
    int         low;
    logic [7:0] b2b [3];
    b2b[0] = 8'h48; b2b[1] = 8'h49; b2b[2] = 8'h21;
    ARESETN = 1'b1; req_valid = 1'b0; req_rs = 1'b0; req_data = 8'h00;
    #2 ARESETN = 1'b0;
    repeat (2) @(negedge ACLK);
    check_reset_vals("por");

    // Power-on init with no requests
    push_init();
    p0 = pulses;
    rel = cyc;
    ARESETN = 1'b1;
    wait_ready("init_ready", 1000);
    chk("init_first_e", 32'(first_rise - rel), 32'(T_PU + 1 + T_SU));
    chk("init_done_set", 32'(init_done), 32'd1);
    chk("init_busy_clear", 32'(busy), 32'd0);
    chk("init_pulse_count", 32'(pulses - p0), 32'd6);
    chk("init_sb_empty", 32'(sb.size()), 32'd0);

    // Data write with full timing, then long/short command contrast
    send(1'b1, 8'h41, 20, 1'b1);
    send(1'b0, 8'h01, 50, 1'b0);
    send(1'b1, 8'h01, 20, 1'b0);
    send(1'b0, 8'h03, 50, 1'b0);
    send(1'b0, 8'h04, 20, 1'b0);

    // Back-to-back with req_valid held
    wait_ready("b2b_ready", 500);
    p0 = pulses;
    for (int i = 0; i < 3; i++) sb.push_back('{1'b1, b2b[i], 0});
    req_valid = 1'b1; req_rs = 1'b1; req_data = b2b[0];
    for (int i = 0; i < 3; i++) begin
      @(posedge ACLK); #1;
      if (i < 2) req_data = b2b[i + 1];
      else req_valid = 1'b0;
      count_low(low);
      chk("b2b_ready_low", 32'(low), 32'd20);
    end
    repeat (5) @(negedge ACLK);
    chk("b2b_pulse_count", 32'(pulses - p0), 32'd3);
    chk("b2b_sb_empty", 32'(sb.size()), 32'd0);

    // Reset while E is high
    wait_ready("rst_ready", 500);
    req_valid = 1'b1; req_rs = 1'b1; req_data = 8'h5A;
    sb.push_back('{1'b1, 8'h5A, 0});
    @(posedge ACLK); #1;
    req_valid = 1'b0;
    n = 0;
    while (!lcd_e && n < 50) begin
      @(negedge ACLK);
      n++;
    end
    if (!lcd_e) fail_to("rst_wait_e");
    #2 ARESETN = 1'b0;
    #1;
    check_reset_vals("async_rst");
    sb.delete();

    // Early request held through the repeated init
    req_valid = 1'b1; req_rs = 1'b1; req_data = 8'h55;
    repeat (3) @(negedge ACLK);
    push_init();
    sb.push_back('{1'b1, 8'h55, 0});
    p0 = pulses;
    rel = cyc;
    ARESETN = 1'b1;
    n = 0;
    while (!req_ready && n < 1000) begin
      @(negedge ACLK);
      n++;
    end
    if (!req_ready) fail_to("early_ready");
    chk("early_init_done_at_ready", 32'(init_done), 32'd1);
    chk("early_pulses_before_accept", 32'(pulses - p0), 32'd6);
    chk("reinit_first_e", 32'(first_rise - rel), 32'(T_PU + 1 + T_SU));
    @(posedge ACLK); #1;
    req_valid = 1'b0;
    count_low(low);
    chk("early_ready_low", 32'(low), 32'd20);
    repeat (30) @(negedge ACLK);
    chk("early_pulse_count", 32'(pulses - p0), 32'd7);
    chk("early_sb_empty", 32'(sb.size()), 32'd0);
    chk("rw_never_high", 32'(rw_bad), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/textlcd_bus_sequencer.md
Name: textlcd_bus_sequencer

Overview:
- Downstream stage of the textlcd AXI4-Lite slave registers.
- Takes one-byte command/data requests over a valid/ready handshake.
- Drives an HD44780-compatible 8-bit parallel LCD bus with programmable setup, enable-pulse, hold and execution timing.
- Runs the LCD power-on initialisation autonomously after reset, and reports busy/init status back to the register file for software polling.

Parameters:
- T_POWERUP, 750000, cycles waited after reset release before the first init command (15 ms at 50 MHz); min 1.
- T_SETUP, 3, cycles RS/DATA are stable before E rises; min 1.
- T_E_HIGH, 12, cycles E is held high; min 1.
- T_HOLD, 3, cycles RS/DATA are held after E falls; min 1.
- T_EXEC, 2500, execution wait after a normal command/data write; min 1.
- T_EXEC_LONG, 82000, execution wait after clear (0x01) or return-home (0x02/0x03) with RS=0; min 1.

Ports:
- ACLK, input, 1, system clock.
- ARESETN, input, 1, asynchronous active-low reset.
- req_valid, input, 1, request present.
- req_ready, output, 1, sequencer accepts a request this cycle.
- req_rs, input, 1, 0 = instruction, 1 = character data.
- req_data, input, 8, byte to write.
- init_done, output, 1, power-on sequence complete (sticky until reset).
- busy, output, 1, transfer or init in progress (equals ~req_ready).
- lcd_rs, output, 1, LCD register select.
- lcd_rw, output, 1, LCD read/write; constant 0 (write-only).
- lcd_e, output, 1, LCD enable strobe.
- lcd_data, output, 8, LCD data bus.

Behaviour:
- Clock and reset: one clock, ACLK. Reset is asynchronous and active-low on ARESETN.
- Registered outputs: all outputs are registered.
- Reset values: req_ready=0, init_done=0, busy=1, lcd_rs=0, lcd_rw=0, lcd_e=0, lcd_data=0x00, state=PWRUP.
- States:
  - PWRUP: count T_POWERUP cycles, then go to LOAD with init index 0.
  - LOAD: latch byte from source (init ROM[idx], or the request captured at accept) into lcd_rs/lcd_data; go to SETUP.
  - SETUP: e=0 for T_SETUP cycles, then E_HIGH.
  - E_HIGH: e=1 for T_E_HIGH cycles, then HOLD.
  - HOLD: e=0 for T_HOLD cycles, with rs/data unchanged; then EXEC.
  - EXEC: wait T_EXEC_LONG if rs=0 and data in {0x01,0x02,0x03}, else T_EXEC.
    - On exit during init: idx++; if idx==6, set init_done and go to IDLE, else go to LOAD.
    - On exit otherwise: go to IDLE.
  - IDLE: req_ready=1. On req_valid&&req_ready at edge k, capture rs/data and go to LOAD.
- Request timing:
  - lcd_rs/lcd_data update at edge k+1.
  - lcd_e rises at edge k+1+T_SETUP.
  - req_ready returns high at edge k+1+T_SETUP+T_E_HIGH+T_HOLD+T_EXEC(_LONG)+1.
  - Total fixed overhead: 2 cycles (LOAD + IDLE re-entry).
- Init sequence: 6 entries, all RS=0: 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06. Entry 4 (0x01) uses T_EXEC_LONG.
- req_ready is 0 throughout PWRUP/init and during any transfer. A held req_valid is not consumed; the source must hold req_rs/req_data stable until accepted.
- Back-to-back: one request per transfer. A request valid in the IDLE cycle is accepted immediately, so there are no idle gaps beyond the 2-cycle overhead.
- lcd_rs/lcd_data change only in LOAD, never while lcd_e=1.
- Reset mid-transfer: lcd_e drops to 0 immediately (async), init_done clears, the sequence restarts from PWRUP, and the in-flight request is discarded.
- Delay counter width: $clog2(max parameter + 1). The counter is loaded with (T-1) and decremented; the state advances when it reaches 0.
- Parameter check: a parameter value of 0 is illegal; elaboration-time check with $error.

Decomposition:
- Package textlcd_pkg holds:
  - state enum;
  - init-ROM depth constant INIT_LEN=6;
  - HD44780 opcode constants (CLEAR=0x01, HOME=0x02, FUNC_8B2L=0x38, DISP_ON=0x0C, ENTRY_INC=0x06);
  - function is_long_cmd(rs, data).
- One sub-module: textlcd_init_rom, a combinational 3-bit-index to {rs, data[7:0]} lookup.
- Timing FSM and counter stay in the top module.

Test Plan:
- Test parameters: T_POWERUP=20, T_SETUP=2, T_E_HIGH=4, T_HOLD=2, T_EXEC=10, T_EXEC_LONG=40.
- Power-on: release ARESETN, no requests.
  - Expect req_ready=0 for 20 cycles.
  - Then 6 E pulses, each 4 cycles wide, carrying 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06 with lcd_rs=0.
  - Gap after 0x01 ≥40 cycles; other gaps ≥10.
  - Then init_done=1 and req_ready=1.
- Data write: accept rs=1, data=0x41 at edge k.
  - Expect lcd_data=0x41 and lcd_rs=1 at k+1, lcd_e high from k+3 to k+7, data held until k+9.
  - req_ready returns high at k+20.
- Long command: accept rs=0, data=0x01.
  - Expect req_ready low for 2+2+4+2+40=50 cycles.
  - Contrast with rs=1, data=0x01, which gives 20 cycles.
- Early request: assert req_valid with 0x55 from cycle 0 of reset release.
  - Expect no acceptance until init_done=1.
  - Then exactly one transfer of 0x55.
  - lcd_data never changes while lcd_e=1.
- Reset mid-pulse: drop ARESETN while lcd_e=1.
  - Expect lcd_e=0, init_done=0 and lcd_data=0x00 within the same cycle (asynchronous).
  - After release, the full init sequence repeats.
- Back-to-back: hold req_valid with bytes 0x48, 0x49, 0x21.
  - Expect 3 transfers in order, each 20 cycles apart, with lcd_rw=0 throughout.
